ioc_bus_master: RTL and testbench
=================================

IOC_BUS_MASTER -- requirements
Module: ioc_bus_master

Interface
REQ-001 Parameter SETUP_CYC, default 1: cycles A/data are driven before the strobe; allowed range 1..15.
REQ-002 Parameter STROBE_CYC, default 2: cycles CSn is low; allowed range 2..15.
REQ-003 Parameter HOLD_CYC, default 1: cycles A/data are held after the strobe; allowed range 1..15.
REQ-004 Parameter POLL_PERIOD, default 1024: clk cycles between poll triggers; allowed range 64..65535.
REQ-005 clk  in  1  single clock; all logic on posedge.
REQ-006 RES_INn  in  1  reset, synchronous, active-low.
REQ-007 host_req  in  1  access request, held high until host_ack.
REQ-008 host_we  in  1  1 = write, 0 = read.
REQ-009 host_addr  in  4  IOC register address.
REQ-010 host_wdata  in  8  write data.
REQ-011 host_ack  out  1  one-cycle completion pulse.
REQ-012 host_rdata  out  8  read data, valid with host_ack, held until the next host read completes.
REQ-013 A  out  4  IOC address.
REQ-014 CSn / WEn / OEn  out  1 each  IOC strobes, active-low.
REQ-015 bus_wdata  out  8  to IOC Din.
REQ-016 bus_rdata  in  8  from IOC Dout (IOC registers it on clk while CSn is low).
REQ-017 poll_en  in  1  enables the periodic input scan.
REQ-018 in_shadow  out  32  last committed IN snapshot.
REQ-019 inb_shadow  out  8  last committed INB snapshot.
REQ-020 poll_done  out  1  one-cycle pulse when the shadows commit.

Function
REQ-021 FSM states: IDLE, SETUP, STROBE, HOLD; each timed state lasts exactly its parameter's cycle count.
REQ-022 IDLE: CSn=WEn=OEn=1; A and bus_wdata hold their last values.
REQ-023 SETUP: A is driven; for writes, bus_wdata is driven; strobes stay high.
REQ-024 STROBE for reads: CSn=0, OEn=0, WEn=1.
REQ-025 STROBE for writes: CSn=0, WEn=0, OEn=1.
REQ-026 Read capture: bus_rdata is sampled on the final STROBE cycle.
REQ-027 HOLD: strobes are high; A and bus_wdata are unchanged.
REQ-028 Transaction end: the FSM returns to IDLE after HOLD; host_ack pulses on that same edge for host transactions.
REQ-029 Host command latch: host_we, host_addr and host_wdata are captured on the IDLE->SETUP edge; changes after that are ignored.
REQ-030 After host_ack, the master does not start a new host transaction in the same cycle, even if host_req is still high; there is at least one IDLE cycle.
REQ-031 Poll timer: while poll_en=1, a 16-bit timer counts up to POLL_PERIOD-1, then sets poll_pending and wraps to 0.
REQ-032 If poll_pending is already set when the timer wraps, the trigger is dropped; there is no queueing.
REQ-033 While poll_en=0, the timer is held at 0; an in-progress scan still completes.
REQ-034 A poll scan is five read slots with A = 0, 1, 2, 3, 7; captured bytes go into a staging register.
REQ-035 On completion of the last slot, the full staging value is copied to in_shadow/inb_shadow in a single cycle, poll_done pulses, and poll_pending clears.
REQ-036 Arbitration in IDLE: a pending host_req beats a pending poll slot; host transactions may interleave between poll slots, but never preempt a started transaction.
REQ-037 Polled reads do not change host_rdata and do not pulse host_ack.
REQ-038 Slot counter: 3 bits, resets to 0 when a scan commits.

Reset
REQ-039 On reset: FSM = IDLE; CSn=WEn=OEn=1; A=0; bus_wdata=0.
REQ-040 On reset: host_ack=0; host_rdata=0.
REQ-041 On reset: in_shadow=0; inb_shadow=0; poll_done=0; poll_pending=0; timer=0; slot=0.
REQ-042 Reset asserted mid-transaction deasserts all strobes on the next edge and aborts the transaction with no ack and no shadow commit.

Structure
REQ-043 Shared package ioc_pkg: FSM state enum, IOC register address constants (IN0..IN3=0..3, COIN=4, INB=7), and the poll address table.
REQ-044 Sub-module ioc_poll_timer: period counter and pending-flag logic; everything else is flat.

Verification
REQ-045 Host write, addr 4, data 0x0F (default params) -> CSn low 2 cycles with WEn low and bus_wdata=0x0F; IOC coin outputs all 1; host_ack 4 cycles after acceptance.
REQ-046 Host read, addr 7, IOC INB=0xA5 -> host_rdata=0xA5 on the host_ack cycle; OEn low only during STROBE.
REQ-047 poll_en=1, POLL_PERIOD=64, IN=0x12345678, INB=0x9C -> after the first scan, in_shadow=0x12345678 and inb_shadow=0x9C with a single poll_done pulse.
REQ-048 host_req raised during poll slot 2 -> host transaction runs between slots 2 and 3; shadows are correct; host_rdata is unaffected by polled data.
REQ-049 RES_INn pulled low during a write STROBE -> strobes high next edge, no host_ack, shadows = 0.
REQ-050 STROBE_CYC=3, HOLD_CYC=2, with back-to-back host requests -> exact strobe widths and at least one IDLE cycle between transactions.

Source files
------------

// File: rtl/ioc_pkg.sv
// Shared state encoding, IOC register map and poll scan order for the IOC bus master.
package ioc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } ioc_state_e;

  localparam logic [3:0] ADDR_IN0  = 4'd0;
  localparam logic [3:0] ADDR_IN1  = 4'd1;
  localparam logic [3:0] ADDR_IN2  = 4'd2;
  localparam logic [3:0] ADDR_IN3  = 4'd3;
  localparam logic [3:0] ADDR_COIN = 4'd4;
  localparam logic [3:0] ADDR_INB  = 4'd7;

  localparam int unsigned POLL_SLOTS     = 5;
  localparam logic [2:0]  POLL_LAST_SLOT = 3'(POLL_SLOTS - 1);

  localparam logic [3:0] POLL_ADDR [POLL_SLOTS] =
    '{ADDR_IN0, ADDR_IN1, ADDR_IN2, ADDR_IN3, ADDR_INB};

  function automatic logic [3:0] poll_addr(input logic [2:0] slot);
    logic [3:0] a;
    a = ADDR_IN0;
    for (int unsigned i = 0; i < POLL_SLOTS; i++) begin
      if (slot == 3'(i)) a = POLL_ADDR[i];
    end
    return a;
  endfunction

endpackage

// File: rtl/ioc_bus_master_if.sv
// Host request/ack handshake plus the IOC strobe bus, bundled for ioc_bus_master.
interface ioc_bus_master_if;
  logic       host_req;
  logic       host_we;
  logic [3:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_ack;
  logic [7:0] host_rdata;
  logic [3:0] A;
  logic       CSn;
  logic       WEn;
  logic       OEn;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;

  modport master (
    input  host_req, host_we, host_addr, host_wdata, bus_rdata,
    output host_ack, host_rdata, A, CSn, WEn, OEn, bus_wdata
  );

  modport slave (
    output host_req, host_we, host_addr, host_wdata, bus_rdata,
    input  host_ack, host_rdata, A, CSn, WEn, OEn, bus_wdata
  );
endinterface

// File: rtl/ioc_poll_timer.sv
// Free-running poll period counter raising a sticky request flag for the input scan.
module ioc_poll_timer #(
  parameter int unsigned POLL_PERIOD = 1024
) (
  input  logic clk,
  input  logic RES_INn,
  input  logic poll_en,
  input  logic clear,
  output logic poll_pending
);

  localparam logic [15:0] LAST = 16'(POLL_PERIOD - 1);

  logic [15:0] timer;
  logic        wrap;

  assign wrap = poll_en && (timer == LAST);

  always_ff @(posedge clk) begin
    if (!RES_INn) begin
      timer        <= '0;
      poll_pending <= 1'b0;
    end else begin
      if (!poll_en || wrap) timer <= '0;
      else                  timer <= timer + 16'd1;
      // A wrap coinciding with clear sees the flag still set, so it is dropped.
      if (clear)     poll_pending <= 1'b0;
      else if (wrap) poll_pending <= 1'b1;
    end
  end

endmodule

// File: rtl/ioc_bus_master.sv
// Timed strobe master for the IOC register bus: host accesses plus a periodic five-slot input scan.
module ioc_bus_master
  import ioc_pkg::*;
#(
  parameter int unsigned SETUP_CYC   = 1,
  parameter int unsigned STROBE_CYC  = 2,
  parameter int unsigned HOLD_CYC    = 1,
  parameter int unsigned POLL_PERIOD = 1024
) (
  input  logic                    clk,
  input  logic                    RES_INn,
  ioc_bus_master_if.master        bus,
  input  logic                    poll_en,
  output logic [31:0]             in_shadow,
  output logic [7:0]              inb_shadow,
  output logic                    poll_done
);

  localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LAST   = 4'(HOLD_CYC - 1);

  ioc_state_e      state;
  logic [3:0]      cnt;
  logic            is_host;
  logic            we_q;
  logic [3:0]      a_q;
  logic [7:0]      wdata_q;
  logic            csn_q, wen_q, oen_q;
  logic            ack_q;
  logic [7:0]      rdata_q;
  logic [7:0]      rd_cap;
  logic [3:0][7:0] staging;
  logic [2:0]      slot;
  logic            poll_pending;
  logic            hold_end;
  logic            commit;

  assign hold_end = (state == ST_HOLD) && (cnt == HOLD_LAST);
  assign commit   = hold_end && !is_host && (slot == POLL_LAST_SLOT);

  ioc_poll_timer #(
    .POLL_PERIOD(POLL_PERIOD)
  ) u_poll_timer (
    .clk         (clk),
    .RES_INn     (RES_INn),
    .poll_en     (poll_en),
    .clear       (commit),
    .poll_pending(poll_pending)
  );

  always_ff @(posedge clk) begin
    if (!RES_INn) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      is_host    <= 1'b0;
      we_q       <= 1'b0;
      a_q        <= '0;
      wdata_q    <= '0;
      csn_q      <= 1'b1;
      wen_q      <= 1'b1;
      oen_q      <= 1'b1;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
      rd_cap     <= '0;
      staging    <= '0;
      slot       <= '0;
      in_shadow  <= '0;
      inb_shadow <= '0;
      poll_done  <= 1'b0;
    end else begin
      ack_q     <= 1'b0;
      poll_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          cnt <= '0;
          // ack_q still high means host_req is the stale hold of the request just acked.
          if (bus.host_req && !ack_q) begin
            state   <= ST_SETUP;
            is_host <= 1'b1;
            we_q    <= bus.host_we;
            a_q     <= bus.host_addr;
            if (bus.host_we) wdata_q <= bus.host_wdata;
          end else if (poll_pending) begin
            state   <= ST_SETUP;
            is_host <= 1'b0;
            we_q    <= 1'b0;
            a_q     <= poll_addr(slot);
          end
        end
        ST_SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt   <= '0;
            state <= ST_STROBE;
            csn_q <= 1'b0;
            if (we_q) wen_q <= 1'b0;
            else      oen_q <= 1'b0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_STROBE: begin
          if (cnt == STROBE_LAST) begin
            cnt    <= '0;
            state  <= ST_HOLD;
            csn_q  <= 1'b1;
            wen_q  <= 1'b1;
            oen_q  <= 1'b1;
            rd_cap <= bus.bus_rdata;
            if (!is_host && !slot[2]) staging[slot[1:0]] <= bus.bus_rdata;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_HOLD: begin
          if (hold_end) begin
            cnt   <= '0;
            state <= ST_IDLE;
            if (is_host) begin
              ack_q <= 1'b1;
              if (!we_q) rdata_q <= rd_cap;
            end else if (commit) begin
              in_shadow  <= staging;
              inb_shadow <= rd_cap;
              poll_done  <= 1'b1;
              slot       <= '0;
            end else begin
              slot <= slot + 3'd1;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
      endcase
    end
  end

  assign bus.A          = a_q;
  assign bus.bus_wdata  = wdata_q;
  assign bus.CSn        = csn_q;
  assign bus.WEn        = wen_q;
  assign bus.OEn        = oen_q;
  assign bus.host_ack   = ack_q;
  assign bus.host_rdata = rdata_q;

endmodule

// File: tb/tb_ioc_bus_master.sv
// Bench for ioc_bus_master: lane 0 uses default timing, lane 1 a 3-cycle strobe / 2-cycle hold.
module tb_ioc_bus_master;
  import ioc_pkg::*;

  localparam int unsigned PERIOD = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rstn;
  logic [1:0]            poll_en, host_req, host_we;
  logic [1:0][3:0]       host_addr;
  logic [1:0][7:0]       host_wdata;
  logic [1:0][3:0][7:0]  ioc_in;
  logic [1:0][7:0]       ioc_inb;
  logic [1:0]            csn_w, wen_w, oen_w, ack_w, done_w;
  logic [1:0][3:0]       a_w;
  logic [1:0][7:0]       wd_w, rdata_w, inbs_w, coin_w;
  logic [1:0][31:0]      ins_w;

  int checks = 0;
  int errors = 0;

  task automatic chk(input int ln, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL lane%0d %s: got %h expected %h at %0t", ln, name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int unsigned S = 1;
    localparam int unsigned T = (g == 0) ? 2 : 3;
    localparam int unsigned H = (g == 0) ? 1 : 2;

    ioc_bus_master_if ifc ();
    logic [31:0] in_sh;
    logic [7:0]  inb_sh;
    logic        pdone;
    logic [7:0]  coin = 8'h00;
    logic [7:0]  dout = 8'h00;

    ioc_bus_master #(
      .SETUP_CYC  (S),
      .STROBE_CYC (T),
      .HOLD_CYC   (H),
      .POLL_PERIOD(PERIOD)
    ) dut (
      .clk       (clk),
      .RES_INn   (rstn),
      .bus       (ifc),
      .poll_en   (poll_en[g]),
      .in_shadow (in_sh),
      .inb_shadow(inb_sh),
      .poll_done (pdone)
    );

    assign ifc.host_req   = host_req[g];
    assign ifc.host_we    = host_we[g];
    assign ifc.host_addr  = host_addr[g];
    assign ifc.host_wdata = host_wdata[g];
    assign ifc.bus_rdata  = dout;

    assign csn_w[g]   = ifc.CSn;
    assign wen_w[g]   = ifc.WEn;
    assign oen_w[g]   = ifc.OEn;
    assign ack_w[g]   = ifc.host_ack;
    assign a_w[g]     = ifc.A;
    assign wd_w[g]    = ifc.bus_wdata;
    assign rdata_w[g] = ifc.host_rdata;
    assign ins_w[g]   = in_sh;
    assign inbs_w[g]  = inb_sh;
    assign done_w[g]  = pdone;
    assign coin_w[g]  = coin;

    function automatic logic [7:0] ioc_reg(input logic [3:0] adr);
      case (adr)
        4'd0, 4'd1, 4'd2, 4'd3: return ioc_in[g][adr[1:0]];
        4'd4:                   return coin;
        4'd7:                   return ioc_inb[g];
        default:                return 8'h00;
      endcase
    endfunction

    // IOC: registers Dout and latches Din while selected
    always @(posedge clk) begin
      if (ifc.CSn === 1'b0) begin
        dout <= ioc_reg(ifc.A);
        if (ifc.WEn === 1'b0) coin <= ifc.bus_wdata;
      end
    end

    // Transaction model: each access is an offset t from its start edge
    bit          armed = 1'b0;
    bit          busy, mhost, mwe, e_ack, e_done, pend;
    int          t, slot, timer;
    logic [3:0]  e_a, maddr;
    logic [7:0]  e_wd, e_rd, cap, e_inb;
    logic [31:0] e_in;
    logic [7:0]  stage [4];

    always @(posedge clk) begin
      bit prev_ack, commit;
      if (rstn === 1'b0) begin
        armed = 1'b1; busy = 1'b0; t = 0; mhost = 1'b0; mwe = 1'b0;
        e_ack = 1'b0; e_done = 1'b0; slot = 0; timer = 0; pend = 1'b0;
        e_a = '0; maddr = '0; e_wd = '0; e_rd = '0; cap = '0; e_in = '0; e_inb = '0;
      end else if (armed) begin
        prev_ack = e_ack; commit = 1'b0; e_ack = 1'b0; e_done = 1'b0;
        if (busy) begin
          t++;
          if (t == S + T) cap = ioc_reg(maddr);
          if (t == S + T + H) begin
            busy = 1'b0;
            if (mhost) begin
              e_ack = 1'b1;
              if (!mwe) e_rd = cap;
            end else if (slot == 4) begin
              e_in = {stage[3], stage[2], stage[1], stage[0]};
              e_inb = cap; e_done = 1'b1; commit = 1'b1; slot = 0;
            end else begin
              stage[slot] = cap; slot++;
            end
          end
        end else if (host_req[g] && !prev_ack) begin
          busy = 1'b1; t = 0; mhost = 1'b1; mwe = host_we[g];
          maddr = host_addr[g]; e_a = maddr;
          if (mwe) e_wd = host_wdata[g];
        end else if (pend) begin
          busy = 1'b1; t = 0; mhost = 1'b0; mwe = 1'b0;
          maddr = (slot == 4) ? 4'd7 : 4'(slot); e_a = maddr;
        end
        if (poll_en[g]) begin
          if (timer == PERIOD - 1) begin timer = 0; pend = 1'b1; end
          else timer++;
        end else begin
          timer = 0;
        end
        if (commit) pend = 1'b0;
      end
    end

    always @(negedge clk) begin
      logic       strobe;
      logic [2:0] e_st;
      if (armed) begin
        strobe = busy && (t >= S) && (t < S + T);
        e_st = !strobe ? 3'b111 : (mwe ? 3'b001 : 3'b010);
        chk(g, "strobes", {29'd0, ifc.CSn, ifc.WEn, ifc.OEn}, {29'd0, e_st});
        chk(g, "A", {28'd0, ifc.A}, {28'd0, e_a});
        chk(g, "bus_wdata", {24'd0, ifc.bus_wdata}, {24'd0, e_wd});
        chk(g, "host_ack", {31'd0, ifc.host_ack}, {31'd0, e_ack});
        chk(g, "host_rdata", {24'd0, ifc.host_rdata}, {24'd0, e_rd});
        chk(g, "in_shadow", in_sh, e_in);
        chk(g, "inb_shadow", {24'd0, inb_sh}, {24'd0, e_inb});
        chk(g, "poll_done", {31'd0, pdone}, {31'd0, e_done});
      end
    end
  end

  task automatic host_op(input int ln, input bit we, input logic [3:0] adr, input logic [7:0] wd,
                         output int lat, output int cs_low, output int we_low, output int wd_bad,
                         output int oe_low, output int oe_bad, output logic [7:0] rd);
    lat = 0; cs_low = 0; we_low = 0; wd_bad = 0; oe_low = 0; oe_bad = 0;
    host_we[ln] = we; host_addr[ln] = adr; host_wdata[ln] = wd; host_req[ln] = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (!csn_w[ln]) cs_low++;
      if (!wen_w[ln]) begin we_low++; if (wd_w[ln] != wd) wd_bad++; end
      if (!oen_w[ln]) begin oe_low++; if (csn_w[ln]) oe_bad++; end
    end while (!ack_w[ln] && lat < 200);
    chk(ln, "ack_seen", {31'd0, ack_w[ln]}, 32'd1);
    rd = rdata_w[ln];
    host_req[ln] = 1'b0;
  endtask

  int          lat, cs_low, we_low, wd_bad, oe_low, oe_bad, pulses, acks, run, gap, ack_at;
  logic [7:0]  rd;
  logic [3:0]  seq [$];
  int          runs [$];
  logic [3:0]  exp_seq [6];
  bit          issued, got_ack, seen_done;
  logic        prev_cs;

  initial begin
    rstn = 1'b0; poll_en = '0; host_req = '0; host_we = '0; host_addr = '0; host_wdata = '0;
    ioc_in = '0; ioc_inb = '0;
    exp_seq = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd7};
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk(0, "rst_strobes", {29'd0, csn_w[0], wen_w[0], oen_w[0]}, 32'd7);
    chk(0, "rst_A", {28'd0, a_w[0]}, 32'd0);
    chk(0, "rst_rdata", {24'd0, rdata_w[0]}, 32'd0);
    chk(0, "rst_in_shadow", ins_w[0], 32'd0);

    // Host write of 0x0F to the coin register
    host_op(0, 1'b1, ADDR_COIN, 8'h0F, lat, cs_low, we_low, wd_bad, oe_low, oe_bad, rd);
    chk(0, "wr_latency", lat, 32'd5);
    chk(0, "wr_cs_width", cs_low, 32'd2);
    chk(0, "wr_we_width", we_low, 32'd2);
    chk(0, "wr_wdata_bad", wd_bad, 32'd0);
    chk(0, "coin_outputs", {28'd0, coin_w[0][3:0]}, 32'hF);
    @(negedge clk);

    // Host read of INB
    ioc_inb[0] = 8'hA5;
    host_op(0, 1'b0, ADDR_INB, 8'h00, lat, cs_low, we_low, wd_bad, oe_low, oe_bad, rd);
    chk(0, "rd_data", {24'd0, rd}, 32'hA5);
    chk(0, "rd_oe_width", oe_low, 32'd2);
    chk(0, "rd_oe_outside_cs", oe_bad, 32'd0);
    chk(0, "rd_latency", lat, 32'd5);
    @(negedge clk);

    // First poll scan
    ioc_in[0] = 32'h12345678; ioc_inb[0] = 8'h9C;
    poll_en[0] = 1'b1;
    pulses = 0; ack_at = -1;
    for (int n = 0; n < 300 && (ack_at < 0 || n < ack_at + 20); n++) begin
      @(negedge clk);
      if (done_w[0]) begin pulses++; if (ack_at < 0) ack_at = n; end
    end
    poll_en[0] = 1'b0;
    chk(0, "poll_done_pulses", pulses, 32'd1);
    chk(0, "scan1_in_shadow", ins_w[0], 32'h12345678);
    chk(0, "scan1_inb_shadow", {24'd0, inbs_w[0]}, 32'h9C);

    // Host read interleaved after poll slot 2
    ioc_in[0] = 32'hCAFEF00D; ioc_inb[0] = 8'h3C;
    @(negedge clk);
    poll_en[0] = 1'b1;
    issued = 1'b0; got_ack = 1'b0; seen_done = 1'b0; prev_cs = 1'b1; rd = 8'h00;
    for (int n = 0; n < 400 && !seen_done; n++) begin
      @(negedge clk);
      if (!csn_w[0] && prev_cs) seq.push_back(a_w[0]);
      prev_cs = csn_w[0];
      if (host_req[0] && ack_w[0]) begin host_req[0] = 1'b0; got_ack = 1'b1; rd = rdata_w[0]; end
      if (!issued && !csn_w[0] && a_w[0] == 4'd2) begin
        issued = 1'b1; host_we[0] = 1'b0; host_addr[0] = ADDR_COIN; host_req[0] = 1'b1;
      end
      if (done_w[0]) seen_done = 1'b1;
    end
    poll_en[0] = 1'b0;
    chk(0, "mix_ack_seen", {31'd0, got_ack}, 32'd1);
    chk(0, "mix_rdata", {24'd0, rd}, 32'h0F);
    chk(0, "mix_seq_len", seq.size(), 32'd6);
    for (int i = 0; i < seq.size() && i < 6; i++) chk(0, "mix_seq_addr", {28'd0, seq[i]}, {28'd0, exp_seq[i]});
    @(negedge clk);
    chk(0, "mix_rdata_after_scan", {24'd0, rdata_w[0]}, 32'h0F);
    chk(0, "scan2_in_shadow", ins_w[0], 32'hCAFEF00D);
    chk(0, "scan2_inb_shadow", {24'd0, inbs_w[0]}, 32'h3C);

    // Reset during a write strobe
    host_we[0] = 1'b1; host_addr[0] = ADDR_COIN; host_wdata[0] = 8'h55; host_req[0] = 1'b1;
    begin
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (csn_w[0] && n < 50);
    end
    chk(0, "rst_wait_strobe", {31'd0, csn_w[0]}, 32'd0);
    rstn = 1'b0; host_req[0] = 1'b0;
    @(negedge clk);
    chk(0, "abort_strobes", {29'd0, csn_w[0], wen_w[0], oen_w[0]}, 32'd7);
    @(negedge clk);
    rstn = 1'b1;
    acks = 0;
    repeat (10) begin @(negedge clk); if (ack_w[0]) acks++; end
    chk(0, "abort_no_ack", acks, 32'd0);
    chk(0, "abort_in_shadow", ins_w[0], 32'd0);
    chk(0, "abort_inb_shadow", {24'd0, inbs_w[0]}, 32'd0);

    // Back-to-back host requests on the stretched lane
    ioc_inb[1] = 8'h5A;
    host_we[1] = 1'b1; host_addr[1] = ADDR_COIN; host_wdata[1] = 8'hA3; host_req[1] = 1'b1;
    acks = 0; run = 0; gap = 0; ack_at = 0;
    for (int n = 0; n < 100 && !(acks == 2 && run == 0); n++) begin
      @(negedge clk);
      if (!csn_w[1]) run++;
      else if (run > 0) begin runs.push_back(run); run = 0; end
      if (ack_w[1]) begin
        acks++;
        if (acks == 1) begin
          ack_at = n; rd = 8'h00;
          host_we[1] = 1'b0; host_addr[1] = ADDR_INB;
        end else begin
          gap = n - ack_at; rd = rdata_w[1]; host_req[1] = 1'b0;
        end
      end
    end
    host_req[1] = 1'b0;
    chk(1, "b2b_acks", acks, 32'd2);
    chk(1, "b2b_runs", runs.size(), 32'd2);
    for (int i = 0; i < runs.size(); i++) chk(1, "b2b_cs_width", runs[i], 32'd3);
    chk(1, "b2b_gap_min", {31'd0, (gap >= 7)}, 32'd1);
    chk(1, "b2b_rdata", {24'd0, rd}, 32'h5A);
    chk(1, "b2b_coin", {24'd0, coin_w[1]}, 32'hA3);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

endmodule
